// File: rtl/usb_hid_pkg.sv
// Shared HID keyboard definitions: modifier masks, typematic FSM encodings, scancode-to-ASCII map.
// Latency: none (types, constants and a pure combinational function).
// Backpressure: not applicable.
package usb_hid_pkg;

   // Left/right shift and left/right ctrl bits of the HID modifier byte
   localparam logic [7:0] SHIFT_MASK = 8'h22;
   localparam logic [7:0] CTRL_MASK  = 8'h11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } tm_state_t;

   // Map a HID usage code plus modifiers to ASCII; 0 means "no printable/control character".
   // Ctrl+letter yields the control code (^A = 0x01); ctrl with any other key yields 0.
   function automatic logic [7:0] scancode2char(input logic [7:0] key, input logic [7:0] mods);
      logic       shift;
      logic       ctrl;
      logic [7:0] c;
      shift = |(mods & SHIFT_MASK);
      ctrl  = |(mods & CTRL_MASK);
      c     = 8'h00;
      if (key >= 8'h04 && key <= 8'h1D) begin
         if (ctrl)
            c = key - 8'h03;
         else if (shift)
            c = 8'h41 + (key - 8'h04);
         else
            c = 8'h61 + (key - 8'h04);
      end else if (!ctrl) begin
         case (key)
            8'h1E: c = shift ? "!"  : "1";
            8'h1F: c = shift ? "@"  : "2";
            8'h20: c = shift ? "#"  : "3";
            8'h21: c = shift ? "$"  : "4";
            8'h22: c = shift ? "%"  : "5";
            8'h23: c = shift ? "^"  : "6";
            8'h24: c = shift ? "&"  : "7";
            8'h25: c = shift ? "*"  : "8";
            8'h26: c = shift ? "("  : "9";
            8'h27: c = shift ? ")"  : "0";
            8'h28: c = 8'h0D;
            8'h29: c = 8'h1B;
            8'h2A: c = 8'h08;
            8'h2B: c = 8'h09;
            8'h2C: c = 8'h20;
            8'h2D: c = shift ? "_"  : "-";
            8'h2E: c = shift ? "+"  : "=";
            8'h2F: c = shift ? "{"  : "[";
            8'h30: c = shift ? "}"  : "]";
            8'h31: c = shift ? "|"  : 8'h5C;
            8'h33: c = shift ? ":"  : ";";
            8'h34: c = shift ? 8'h22 : 8'h27;
            8'h35: c = shift ? "~"  : 8'h60;
            8'h36: c = shift ? "<"  : ",";
            8'h37: c = shift ? ">"  : ".";
            8'h38: c = shift ? "?"  : "/";
            default: c = 8'h00;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Character FIFO: DEPTH entries, power-of-two, pointer-indexed head with zero output when empty.
// Latency: a push is visible at the head/count one cycle later; head is read combinationally from storage.
// Backpressure: push while full is refused unless a pop happens the same cycle; pop while empty is ignored.
module key_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_vld,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop_vld,
   output logic [W-1:0]             head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty    = (cnt == '0);
   assign full     = (cnt == (AW+1)'(DEPTH));
   // a pop frees the slot the push needs, so push+pop works even when full
   assign do_push  = push_vld && (!full || pop_vld);
   assign do_pop   = pop_vld && !empty;
   assign head_dat = empty ? '0 : mem[rd_ptr];
   assign count    = cnt;

   // Storage write; contents are don't-care until counted, so no reset
   always_ff @(posedge clk_i) begin
      if (do_push)
         mem[wr_ptr] <= push_dat;
   end

   // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/usb_key_buffer.sv
// USB keyboard character buffer: HID reports -> ASCII with typematic auto-repeat, queued for a CPU.
// Latency: a press or repeat expiry shows on data_o/avail_o/count_o one cycle later.
// Backpressure: none toward the HID side; characters pushed into a full FIFO are dropped and flagged sticky.
module usb_key_buffer
   import usb_hid_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int DELAY_CYC = 6_000_000,
   parameter int RATE_CYC  = 600_000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    report_i,
   input  logic [7:0]              key1_i,
   input  logic [7:0]              modifiers_i,
   input  logic                    rd_i,
   input  logic                    clr_ovf_i,
   output logic [7:0]              data_o,
   output logic                    avail_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    overflow_o
);
   localparam int TMAX = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] DLY_LOAD  = TW'(DELAY_CYC - 1);
   localparam logic [TW-1:0] RATE_LOAD = TW'(RATE_CYC - 1);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("usb_key_buffer: DEPTH must be a power of two and at least 4");
   end

   tm_state_t     state;
   logic [7:0]    hkey;
   logic [7:0]    hchar;
   logic [TW-1:0] timer;

   logic          rpt_rel;
   logic          rpt_new;
   logic [7:0]    new_chr;
   logic          expire;
   logic          push_vld;
   logic [7:0]    push_dat;
   logic          fifo_full;
   logic          fifo_empty;
   logic          ovf_evt;

   // Report decode. Codes 1..3 (error/rollover) and a repeat of the held key
   // are neither release nor new press, so they leave the FSM and timer alone.
   assign rpt_rel  = report_i && (key1_i == 8'h00);
   assign rpt_new  = report_i && (key1_i >= 8'h04) && (key1_i != hkey);
   assign new_chr  = scancode2char(key1_i, modifiers_i);
   assign expire   = (state != ST_IDLE) && (timer == '0);

   // A release or new press in the expiry cycle wins; the stale repeat is discarded.
   assign push_vld = (rpt_new && (new_chr != 8'h00)) || (expire && !rpt_rel && !rpt_new);
   assign push_dat = rpt_new ? new_chr : hchar;

   // Drop only when full and no simultaneous pop makes room
   assign ovf_evt  = push_vld && fifo_full && !rd_i;

   // Typematic FSM: press -> DELAY -> REPEAT, with held key/char and countdown timer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
         hkey  <= 8'h00;
         hchar <= 8'h00;
         timer <= '0;
      end else if (rpt_rel) begin
         hkey  <= 8'h00;
         state <= ST_IDLE;
      end else if (rpt_new) begin
         hkey <= key1_i;
         if (new_chr != 8'h00) begin
            hchar <= new_chr;
            timer <= DLY_LOAD;
            state <= ST_DELAY;
         end else begin
            state <= ST_IDLE;
         end
      end else if (state != ST_IDLE) begin
         if (timer == '0) begin
            timer <= RATE_LOAD;
            state <= ST_REPEAT;
         end else begin
            timer <= timer - 1'b1;
         end
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         overflow_o <= 1'b0;
      else if (ovf_evt)
         overflow_o <= 1'b1;
      else if (clr_ovf_i)
         overflow_o <= 1'b0;
   end

   key_fifo #(
      .DEPTH (DEPTH),
      .W     (8)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_vld  (rd_i),
      .head_dat (data_o),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (count_o)
   );

   assign avail_o = !fifo_empty;

endmodule
